// File: rtl/exu_issue_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// exu_issue_ctrl_pkg
//   Shared types and constants for the execute-unit issue controller:
//   FSM state encoding, MulOp class constant, datapath widths and a helper
//   that classifies an op as multi-cycle (MUL/DIV).
// ----------------------------------------------------------------------------
package exu_issue_ctrl_pkg;

    localparam int XLEN    = 64;
    localparam int ALUOP_W = 5;
    localparam int MULOP_W = 2;
    localparam int REG_W   = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [MULOP_W-1:0] MULOP_NONE = 2'b00;

    // Any non-zero MulOp belongs to the multi-cycle MUL/DIV class.
    function automatic logic is_multicycle(input logic [MULOP_W-1:0] mulop);
        return mulop != MULOP_NONE;
    endfunction

endpackage

// File: rtl/exu_res_buf.sv
// ----------------------------------------------------------------------------
// exu_res_buf
//   One-entry valid/ready result buffer between the execute unit and WB.
//   A capture always wins over a drain in the same cycle, so back-to-back
//   results stream at one per cycle while WB keeps out_ready high.
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   flush           drop the buffered entry
//   cap             load cap_res/cap_rd this cycle (only issued when buf_free)
//   out_ready       WB takes the entry
//   out_valid/out_res/out_rd  buffered entry toward WB
//   buf_free        buffer can accept a capture this cycle
// ----------------------------------------------------------------------------
module exu_res_buf
    import exu_issue_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             cap,
    input  logic [XLEN-1:0]  cap_res,
    input  logic [REG_W-1:0] cap_rd,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_res,
    output logic [REG_W-1:0] out_rd,
    output logic             buf_free
);

    logic             valid_q, valid_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic [REG_W-1:0] rd_q, rd_d;

    assign buf_free = !valid_q | out_ready;

    always_comb begin
        valid_d = valid_q;
        res_d   = res_q;
        rd_d    = rd_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (cap) begin
            valid_d = 1'b1;
            res_d   = cap_res;
            rd_d    = cap_rd;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
        end
    end

    assign out_valid = valid_q;
    assign out_res   = res_q;
    assign out_rd    = rd_q;

endmodule

// File: rtl/exu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// exu_issue_ctrl
//   Issue and completion controller for the 64-bit execute unit. Accepts
//   decoded ops from ID, launches them into the ALU, waits out multi-cycle
//   MUL/DIV ops (with a timeout), and hands results to WB through a one-entry
//   buffer. mwb_block freezes the ALU while WB back-pressures.
//
// Configuration
//   EXU_CTRL_PERF_EN  when defined, perf_ops/perf_busy count completed ops and
//                     WAIT cycles; otherwise both are tied to zero.
//
// Ports
//   clk, rst                         clock, asynchronous active-low reset
//   flush                            kill in-flight op and buffered result
//   in_valid/in_ready/in_aluop/in_mulop/in_rd   op handshake from ID
//   alu_start, alu_op, mul_op, alu_flush        control toward ALU
//   alu_busy, alu_res                            status/result from ALU
//   mwb_block                        WB stall toward ALU
//   out_valid/out_ready/out_res/out_rd          result handshake toward WB
//   err_timeout                      sticky WAIT timeout flag
//   perf_ops, perf_busy              performance counters
// ----------------------------------------------------------------------------
module exu_issue_ctrl
    import exu_issue_ctrl_pkg::*;
#(
    parameter int MAX_LAT = 128,
    parameter int LAT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ALUOP_W-1:0] in_aluop,
    input  logic [MULOP_W-1:0] in_mulop,
    input  logic [REG_W-1:0]   in_rd,
    output logic               alu_start,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [MULOP_W-1:0] mul_op,
    output logic               alu_flush,
    input  logic               alu_busy,
    input  logic [XLEN-1:0]    alu_res,
    output logic               mwb_block,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_res,
    output logic [REG_W-1:0]   out_rd,
    output logic               err_timeout,
    output logic [31:0]        perf_ops,
    output logic [31:0]        perf_busy
);

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
    logic [MULOP_W-1:0] mul_op_q, mul_op_d;
    logic [REG_W-1:0]   rd_q, rd_d;
    logic               err_q, err_d;

    logic               buf_free;
    logic               accept;
    logic               in_wait;
    logic               wait_done;
    logic               timeout;
    logic               cap;
    logic [XLEN-1:0]    cap_res;
    logic [REG_W-1:0]   cap_rd;

    // Qualified with rst so every output reads 0 while reset is held.
    assign in_ready = rst & (state_q == ST_IDLE) & buf_free & !flush;
    assign accept   = in_valid & in_ready;
    assign in_wait  = (state_q == ST_WAIT);

    // cnt_q==0 marks the first WAIT cycle, where alu_busy is not yet reliable.
    assign wait_done = in_wait & !flush & (cnt_q != '0) & !alu_busy & buf_free;
    // >= rather than == so a timeout stalled behind a full buffer still fires.
    assign timeout   = in_wait & !flush & (cnt_q >= LAT_W'(MAX_LAT)) & alu_busy & buf_free;

    assign cap     = (accept & !is_multicycle(in_mulop)) | wait_done | timeout;
    assign cap_res = timeout ? '0 : alu_res;
    assign cap_rd  = accept ? in_rd : rd_q;

    assign alu_start = accept;
    assign alu_flush = in_wait & (flush | timeout);
    assign mwb_block = out_valid & !out_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        alu_op_d = alu_op_q;
        mul_op_d = mul_op_q;
        rd_d     = rd_q;
        err_d    = err_q | timeout;
        if (accept) begin
            alu_op_d = in_aluop;
            mul_op_d = in_mulop;
            rd_d     = in_rd;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept && is_multicycle(in_mulop)) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + LAT_W'(1);
                if (flush || wait_done || timeout) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            alu_op_q <= '0;
            mul_op_q <= '0;
            rd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            alu_op_q <= alu_op_d;
            mul_op_q <= mul_op_d;
            rd_q     <= rd_d;
            err_q    <= err_d;
        end
    end

    assign alu_op      = alu_op_q;
    assign mul_op      = mul_op_q;
    assign err_timeout = err_q;

    exu_res_buf u_res_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .cap       (cap),
        .cap_res   (cap_res),
        .cap_rd    (cap_rd),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_res   (out_res),
        .out_rd    (out_rd),
        .buf_free  (buf_free)
    );

`ifdef EXU_CTRL_PERF_EN
    logic [31:0] perf_ops_q;
    logic [31:0] perf_busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_ops_q  <= '0;
            perf_busy_q <= '0;
        end else begin
            if (cap)     perf_ops_q  <= perf_ops_q + 32'd1;
            if (in_wait) perf_busy_q <= perf_busy_q + 32'd1;
        end
    end

    assign perf_ops  = perf_ops_q;
    assign perf_busy = perf_busy_q;
`else
    assign perf_ops  = '0;
    assign perf_busy = '0;
`endif

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_exu_issue_ctrl
//   Directed scenarios followed by randomized traffic. A transaction-level
//   reference model (in-flight flag, WAIT age, result queue) predicts every
//   output each cycle.
// ----------------------------------------------------------------------------
module tb_exu_issue_ctrl;

    localparam int MAX_LAT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_aluop;
    logic [1:0]  in_mulop;
    logic [4:0]  in_rd;
    logic        alu_start;
    logic [4:0]  alu_op;
    logic [1:0]  mul_op;
    logic        alu_flush;
    logic        alu_busy;
    logic [63:0] alu_res;
    logic        mwb_block;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_res;
    logic [4:0]  out_rd;
    logic        err_timeout;
    logic [31:0] perf_ops;
    logic [31:0] perf_busy;

    always #5 clk = ~clk;

    exu_issue_ctrl #(.MAX_LAT(MAX_LAT), .LAT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_aluop    (in_aluop),
        .in_mulop    (in_mulop),
        .in_rd       (in_rd),
        .alu_start   (alu_start),
        .alu_op      (alu_op),
        .mul_op      (mul_op),
        .alu_flush   (alu_flush),
        .alu_busy    (alu_busy),
        .alu_res     (alu_res),
        .mwb_block   (mwb_block),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_res     (out_res),
        .out_rd      (out_rd),
        .err_timeout (err_timeout),
        .perf_ops    (perf_ops),
        .perf_busy   (perf_busy)
    );

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
    } ent_t;

    // Reference model state
    ent_t        m_buf[$];
    bit          m_wait;
    int          m_age;
    logic [4:0]  m_rd;
    logic [4:0]  m_aluop;
    logic [1:0]  m_mulop;
    bit          m_err;
    logic [31:0] m_ops;
    logic [31:0] m_busyc;
    int          busy_left;
    int          next_lat;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_buf.delete();
        m_wait    = 1'b0;
        m_age     = 0;
        m_rd      = '0;
        m_aluop   = '0;
        m_mulop   = '0;
        m_err     = 1'b0;
        m_ops     = '0;
        m_busyc   = '0;
        busy_left = 0;
    endtask

    task automatic chk_perf();
`ifdef EXU_CTRL_PERF_EN
        chk("perf_ops", perf_ops, m_ops);
        chk("perf_busy", perf_busy, m_busyc);
`else
        chk("perf_ops", perf_ops, 0);
        chk("perf_busy", perf_busy, 0);
`endif
    endtask

    // One clock: called at a negedge with inputs already driven. Checks all
    // outputs against the model, advances the model, returns at next negedge.
    task automatic cycle();
        bit   free, acc, done, tmo;
        ent_t e;
        alu_busy = m_wait && (busy_left > 0);
        #1;
        if (!rst) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_alu_start", alu_start, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_err", err_timeout, 0);
            chk("rst_alu_op", alu_op, 0);
            @(posedge clk);
            @(negedge clk);
            return;
        end
        free = (m_buf.size() == 0) || out_ready;
        acc  = in_valid && !m_wait && free && !flush;
        done = !flush && m_wait && (m_age >= 1) && !alu_busy && free;
        tmo  = !flush && m_wait && (m_age >= MAX_LAT) && alu_busy && free;

        chk("in_ready", in_ready, !m_wait && free && !flush);
        chk("alu_start", alu_start, acc);
        chk("alu_flush", alu_flush, m_wait && (flush || tmo));
        chk("mwb_block", mwb_block, (m_buf.size() != 0) && !out_ready);
        chk("out_valid", out_valid, m_buf.size() != 0);
        if (m_buf.size() != 0) begin
            chk("out_res", out_res, m_buf[0].res);
            chk("out_rd", out_rd, m_buf[0].rd);
        end
        chk("alu_op", alu_op, m_aluop);
        chk("mul_op", mul_op, m_mulop);
        chk("err_timeout", err_timeout, m_err);
        chk_perf();

        if (m_wait) m_busyc++;
        if (alu_busy && busy_left > 0) busy_left--;
        if (flush) begin
            m_buf.delete();
            m_wait    = 1'b0;
            busy_left = 0;
        end else begin
            if (out_ready && m_buf.size() != 0) void'(m_buf.pop_front());
            if (acc) begin
                m_aluop = in_aluop;
                m_mulop = in_mulop;
                m_rd    = in_rd;
                if (in_mulop == 2'b00) begin
                    e.res = alu_res;
                    e.rd  = in_rd;
                    m_buf.push_back(e);
                    m_ops++;
                    $display("[%0t] single op rd=%0d res=0x%0h", $time, in_rd, alu_res);
                end else begin
                    m_wait    = 1'b1;
                    m_age     = 0;
                    busy_left = next_lat;
                    $display("[%0t] muldiv issue rd=%0d mulop=%0d lat=%0d", $time, in_rd, in_mulop, next_lat);
                end
            end else if (done || tmo) begin
                e.res = tmo ? 64'd0 : alu_res;
                e.rd  = m_rd;
                m_buf.push_back(e);
                m_ops++;
                m_wait = 1'b0;
                if (tmo) m_err = 1'b1;
                $display("[%0t] muldiv %s rd=%0d res=0x%0h", $time, tmo ? "timeout" : "done", m_rd, e.res);
            end else if (m_wait) begin
                m_age++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic issue(input logic [4:0] aluop, input logic [1:0] mulop,
                         input logic [4:0] rd, input logic [63:0] res);
        in_valid = 1'b1;
        in_aluop = aluop;
        in_mulop = mulop;
        in_rd    = rd;
        alu_res  = res;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_aluop  = '0;
        in_mulop  = '0;
        in_rd     = '0;
        alu_busy  = 1'b0;
        alu_res   = '0;
        out_ready = 1'b1;
        next_lat  = 0;
        model_reset();
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();

        // Single-cycle stream of three ops
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_aluop = 5'd1;
            in_mulop = 2'b00;
            in_rd    = 5'(5 + i);
            alu_res  = 64'(16 * (i + 1));
            cycle();
        end
        idle_inputs();
        repeat (3) cycle();

        // MUL with four busy cycles
        next_lat = 4;
        issue(5'd3, 2'b01, 5'd9, 64'h0);
        alu_res = 64'hDEAD;
        repeat (8) cycle();

        // Result held under WB back-pressure, then drained
        next_lat = 3;
        issue(5'd4, 2'b10, 5'd12, 64'h0);
        alu_res = 64'hDEAD;
        cycle();
        out_ready = 1'b0;
        repeat (7) cycle();
        out_ready = 1'b1;
        repeat (2) cycle();

        // Timeout with alu_busy stuck high
        next_lat = 40;
        issue(5'd7, 2'b11, 5'd21, 64'h0);
        alu_res = 64'h1234;
        repeat (14) cycle();

        // Flush in WAIT: no late result when busy drops
        next_lat = 5;
        issue(5'd2, 2'b01, 5'd17, 64'h0);
        repeat (2) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        alu_res = 64'hBEEF;
        repeat (8) cycle();

        // Asynchronous reset while in WAIT
        next_lat = 20;
        issue(5'd6, 2'b01, 5'd3, 64'h0);
        repeat (3) cycle();
        #2;
        rst = 1'b0;
        #1;
        chk("async_in_ready", in_ready, 0);
        chk("async_out_valid", out_valid, 0);
        chk("async_alu_flush", alu_flush, 0);
        chk("async_err", err_timeout, 0);
        chk("async_mul_op", mul_op, 0);
        chk("async_mwb", mwb_block, 0);
        chk("async_perf_busy", perf_busy, 0);
        model_reset();
        @(negedge clk);
        cycle();
        rst = 1'b1;
        cycle();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_aluop  = 5'($urandom);
            in_mulop  = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'b00;
            in_rd     = 5'($urandom);
            alu_res   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            next_lat  = $urandom_range(0, 11);
            cycle();
        end
        idle_inputs();
        out_ready = 1'b1;
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
